// File: rtl/axis_serializer.sv
// Wide-to-narrow AXI-Stream serializer: splits each WIDTH*COUNT input word into COUNT lanes.
// Define AXIS_SERIALIZER_MSB_FIRST_EN to emit the most significant lane first (default LSB first).
module axis_serializer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned COUNT = 4
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic [WIDTH*COUNT-1:0]   idata,
  input  logic                     ivalid,
  output logic                     iready,
  output logic [WIDTH-1:0]         odata,
  output logic                     ovalid,
  input  logic                     oready,
  output logic                     olast
);

  localparam int unsigned DataW = WIDTH * COUNT;
  localparam int unsigned IdxW  = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(COUNT - 1);

  logic [DataW-1:0] sr_q, sr_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             ovalid_q, ovalid_d;
  logic             olast_q, olast_d;
  logic             in_fire, out_fire;

  assign iready   = !ovalid_q || (oready && olast_q);
  assign in_fire  = ivalid && iready;
  assign out_fire = ovalid_q && oready;

  always_comb begin
    sr_d     = sr_q;
    idx_d    = idx_q;
    ovalid_d = ovalid_q;
    if (in_fire) begin
      // Load takes priority: covers both the idle case and the no-bubble reload on olast.
      sr_d     = idata;
      idx_d    = '0;
      ovalid_d = 1'b1;
    end else if (out_fire) begin
      if (olast_q) begin
        ovalid_d = 1'b0;
      end else begin
`ifdef AXIS_SERIALIZER_MSB_FIRST_EN
        sr_d = sr_q << WIDTH;
`else
        sr_d = sr_q >> WIDTH;
`endif
        idx_d = idx_q + IdxW'(1);
      end
    end
    olast_d = ovalid_d && (idx_d == LastIdx);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      ovalid_q <= 1'b0;
      olast_q  <= 1'b0;
      idx_q    <= '0;
    end else begin
      ovalid_q <= ovalid_d;
      olast_q  <= olast_d;
      idx_q    <= idx_d;
    end
  end

  // Data path is intentionally left out of reset.
  always_ff @(posedge clock) begin
    sr_q <= sr_d;
  end

`ifdef AXIS_SERIALIZER_MSB_FIRST_EN
  assign odata = sr_q[DataW-1 -: WIDTH];
`else
  assign odata = sr_q[WIDTH-1:0];
`endif

  assign ovalid = ovalid_q;
  assign olast  = olast_q;

endmodule

// File: tb/tb_axis_serializer.sv
// Directed and random self-checking bench for axis_serializer (WIDTH=8, COUNT=4).
// Inputs are driven and outputs sampled on the falling edge.
module tb_axis_serializer;

  logic        clock;
  logic        resetn;
  logic [31:0] idata;
  logic        ivalid;
  logic        iready;
  logic [7:0]  odata;
  logic        ovalid;
  logic        oready;
  logic        olast;

  int pass_cnt  = 0;
  int total_cnt = 0;

  axis_serializer #(.WIDTH(8), .COUNT(4)) dut (
    .clock  (clock),
    .resetn (resetn),
    .idata  (idata),
    .ivalid (ivalid),
    .iready (iready),
    .odata  (odata),
    .ovalid (ovalid),
    .oready (oready),
    .olast  (olast)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] lane(input logic [31:0] w, input int k);
`ifdef AXIS_SERIALIZER_MSB_FIRST_EN
    return w[8*(3-k) +: 8];
`else
    return w[8*k +: 8];
`endif
  endfunction

  task automatic test_reset();
    resetn = 1'b0;
    ivalid = 1'b0;
    oready = 1'b1;
    idata  = '0;
    repeat (2) @(negedge clock);
    total_cnt++;
    if (ovalid !== 1'b0) $display("FAIL reset_ovalid got %b want 0", ovalid); else pass_cnt++;
    total_cnt++;
    if (olast !== 1'b0) $display("FAIL reset_olast got %b want 0", olast); else pass_cnt++;
    total_cnt++;
    if (iready !== 1'b1) $display("FAIL reset_iready got %b want 1", iready); else pass_cnt++;
    resetn = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_single();
    logic [31:0] w = 32'h44332211;
    idata  = w;
    ivalid = 1'b1;
    #1;
    total_cnt++;
    if (iready !== 1'b1) $display("FAIL single_idle_iready got %b want 1", iready); else pass_cnt++;
    @(negedge clock);
    ivalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      total_cnt++;
      if (ovalid !== 1'b1 || odata !== lane(w, k) || olast !== (k == 3) || iready !== (k == 3))
        $display("FAIL single_beat%0d got v=%b d=%h l=%b r=%b want v=1 d=%h l=%b r=%b",
                 k, ovalid, odata, olast, iready, lane(w, k), (k == 3), (k == 3));
      else pass_cnt++;
      @(negedge clock);
    end
    total_cnt++;
    if (ovalid !== 1'b0) $display("FAIL single_done_ovalid got %b want 0", ovalid); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] wa = 32'hA3A2A1A0;
    logic [31:0] wb = 32'hB3B2B1B0;
    logic [31:0] w;
    idata  = wa;
    ivalid = 1'b1;
    @(negedge clock);
    idata = wb;
    for (int b = 0; b < 8; b++) begin
      if (b == 4) ivalid = 1'b0;
      #1;
      w = (b < 4) ? wa : wb;
      total_cnt++;
      if (ovalid !== 1'b1 || odata !== lane(w, b % 4) || olast !== (b % 4 == 3) ||
          iready !== (b % 4 == 3))
        $display("FAIL b2b_beat%0d got v=%b d=%h l=%b r=%b want v=1 d=%h l=%b r=%b",
                 b, ovalid, odata, olast, iready, lane(w, b % 4), (b % 4 == 3), (b % 4 == 3));
      else pass_cnt++;
      @(negedge clock);
    end
    total_cnt++;
    if (ovalid !== 1'b0) $display("FAIL b2b_done_ovalid got %b want 0", ovalid); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [31:0] w = 32'h44332211;
    int k = 0;
    int xfers = 0;
    int budget = 20;
    idata  = w;
    ivalid = 1'b1;
    @(negedge clock);
    ivalid = 1'b0;
    // Beat 0 transfers, then stall 3 cycles on beat 1.
    @(negedge clock);
    xfers++;
    k = 1;
    oready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clock);
      total_cnt++;
      if (ovalid !== 1'b1 || odata !== lane(w, 1) || olast !== 1'b0)
        $display("FAIL bp_stall%0d got v=%b d=%h l=%b want v=1 d=%h l=0",
                 s, ovalid, odata, olast, lane(w, 1));
      else pass_cnt++;
    end
    oready = 1'b1;
    while (ovalid && budget > 0) begin
      total_cnt++;
      if (k > 3 || odata !== lane(w, k) || olast !== (k == 3))
        $display("FAIL bp_resume%0d got d=%h l=%b want d=%h l=%b",
                 k, odata, olast, lane(w, k & 3), (k == 3));
      else pass_cnt++;
      xfers++;
      k++;
      budget--;
      @(negedge clock);
    end
    total_cnt++;
    if (xfers !== 4) $display("FAIL bp_xfer_count got %0d want 4", xfers); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] w = 32'h44332211;
    logic [31:0] w2 = 32'h0D0C0B0A;
    idata  = w;
    ivalid = 1'b1;
    @(negedge clock);
    ivalid = 1'b0;
    repeat (2) @(negedge clock);
    total_cnt++;
    if (odata !== lane(w, 2)) $display("FAIL rst_mid_pre got d=%h want %h", odata, lane(w, 2));
    else pass_cnt++;
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    #1;
    total_cnt++;
    if (ovalid !== 1'b0 || iready !== 1'b1 || olast !== 1'b0)
      $display("FAIL rst_mid_state got v=%b r=%b l=%b want v=0 r=1 l=0", ovalid, iready, olast);
    else pass_cnt++;
    idata  = w2;
    ivalid = 1'b1;
    @(negedge clock);
    ivalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      total_cnt++;
      if (ovalid !== 1'b1 || odata !== lane(w2, k) || olast !== (k == 3))
        $display("FAIL rst_mid_beat%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                 k, ovalid, odata, olast, lane(w2, k), (k == 3));
      else pass_cnt++;
      @(negedge clock);
    end
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    logic [7:0] exp_d;
    int beat = 0;
    int budget = 200;
    bit in_fire, out_fire;
    for (int c = 0; c < 10000; c++) begin
      idata  = $urandom;
      ivalid = 1'($urandom_range(0, 1));
      oready = 1'($urandom_range(0, 3) != 0);
      #1;
      total_cnt++;
      if (ovalid !== (q.size() != 0))
        $display("FAIL rnd_ovalid cyc %0d got %b want %b", c, ovalid, (q.size() != 0));
      else pass_cnt++;
      in_fire  = ivalid && iready;
      out_fire = ovalid && oready;
      if (out_fire && q.size() != 0) begin
        exp_d = q.pop_front();
        total_cnt++;
        if (odata !== exp_d || olast !== (beat == 3))
          $display("FAIL rnd_beat cyc %0d got d=%h l=%b want d=%h l=%b",
                   c, odata, olast, exp_d, (beat == 3));
        else pass_cnt++;
        beat = (beat + 1) % 4;
      end
      if (in_fire) for (int k = 0; k < 4; k++) q.push_back(lane(idata, k));
      @(negedge clock);
    end
    ivalid = 1'b0;
    oready = 1'b1;
    while (q.size() != 0 && budget > 0) begin
      #1;
      exp_d = q.pop_front();
      total_cnt++;
      if (ovalid !== 1'b1 || odata !== exp_d || olast !== (beat == 3))
        $display("FAIL rnd_drain got v=%b d=%h l=%b want v=1 d=%h l=%b",
                 ovalid, odata, olast, exp_d, (beat == 3));
      else pass_cnt++;
      beat = (beat + 1) % 4;
      budget--;
      @(negedge clock);
    end
    total_cnt++;
    if (ovalid !== 1'b0 || q.size() != 0)
      $display("FAIL rnd_end got v=%b qsize=%0d want v=0 qsize=0", ovalid, q.size());
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/axis_serializer.md
AXIS_SERIALIZER -- requirements
Module: axis_serializer

Interface
REQ-001 Parameter WIDTH, default 8, output lane width in bits; SHALL be at least 1.
REQ-002 Parameter COUNT, default 4, number of output lanes per input word; SHALL be at least 1.
REQ-003 Port clock, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-004 Port resetn, input, 1 bit; reset SHALL be synchronous and active-low.
REQ-005 Port idata, input, WIDTH*COUNT bits, wide input word.
REQ-006 Port ivalid, input, 1 bit, idata is valid.
REQ-007 Port iready, output, 1 bit, block accepts idata this cycle.
REQ-008 Port odata, output, WIDTH bits, current lane; SHALL be registered.
REQ-009 Port ovalid, output, 1 bit, odata is valid; SHALL be registered.
REQ-010 Port oready, input, 1 bit, downstream consumes odata.
REQ-011 Port olast, output, 1 bit, odata is the final lane of its word; SHALL be registered.

Function
REQ-012 A transfer SHALL occur on a port only when its valid and ready signals are both high at the rising clock edge.
REQ-013 The block SHALL hold a shift register of WIDTH*COUNT bits and a lane index of ceil(log2(COUNT)) bits, minimum 1 bit.
REQ-014 iready SHALL be combinational: iready = !ovalid || (oready && olast).
REQ-015 On input acceptance: load the shift register from idata; set the index to 0; present lane 0 on odata with ovalid high from the next cycle.
REQ-016 Acceptance latency SHALL be exactly 1 cycle (idata accepted at edge N gives the first lane valid after edge N).
REQ-017 On an output transfer with olast low: shift by one lane; increment the index; keep ovalid high.
REQ-018 On an output transfer with olast high and no simultaneous input: drop ovalid to 0.
REQ-019 On an output transfer with olast high and a simultaneous input acceptance: load the new word with no bubble; sustained throughput SHALL be one input word per COUNT cycles.
REQ-020 While ovalid is high and oready is low, odata, olast and the index SHALL hold their values.
REQ-021 olast SHALL be high exactly when ovalid is high and the index equals COUNT-1.
REQ-022 With COUNT=1, olast SHALL equal ovalid and the block SHALL behave as a one-deep registered stage.
REQ-023 When ovalid is low, the contents of odata SHALL be don't-care.
REQ-024 No lane SHALL ever be dropped or duplicated; each accepted word SHALL yield exactly COUNT output transfers, in order.

Reset
REQ-025 While resetn is low at a rising edge: ovalid is 0, olast is 0, index is 0, and consequently iready is 1.
REQ-026 The data path (shift register, odata) SHALL NOT be reset.
REQ-027 Reset mid-word SHALL discard the remaining lanes; after reset, the first output SHALL be lane 0 of the next accepted word.

Configuration
REQ-028 Macro AXIS_SERIALIZER_MSB_FIRST_EN SHALL select the lane order.
REQ-029 Without the macro, lane 0 SHALL be idata[WIDTH-1:0] (LSB first).
REQ-030 With the macro, lane 0 SHALL be idata[WIDTH*COUNT-1:WIDTH*(COUNT-1)] (MSB first).
REQ-031 Handshake timing SHALL be identical in both builds.

Verification (WIDTH=8, COUNT=4, oready high unless stated)
REQ-032 Single word: idata=32'h44332211, one ivalid pulse -> odata 11,22,33,44 on 4 consecutive cycles; olast only with 44; iready low for 3 of them. With AXIS_SERIALIZER_MSB_FIRST_EN, the order SHALL be 44,33,22,11.
REQ-033 Back-to-back: ivalid held with words 32'hA3A2A1A0 then 32'hB3B2B1B0 -> 8 contiguous output beats with no bubble; iready high only in the olast cycles.
REQ-034 Backpressure: oready low for 3 cycles while 22 is presented -> odata stays 22 and the index holds; the sequence resumes with 33; the total output transfers per word is 4.
REQ-035 Reset mid-word: assert resetn low after 11 and 22 are transferred -> next cycle ovalid=0 and iready=1; the next word 32'h0D0C0B0A yields 0A first.
REQ-036 Random stress: random ivalid/oready over 10k cycles against a reference queue -> output stream matches lane-split input; olast every 4th beat.
